// File: rtl/gray_conv_pkg.sv
// +----------------------------------------------------------------------------+
// | gray_conv_pkg: types and constants shared across the excess-3 to Gray chain |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package gray_conv_pkg;

    localparam int CODE_W = 4;

    typedef logic [CODE_W-1:0] code_t;

    typedef struct packed {
        logic  err;
        code_t code;
    } entry_t;

    localparam code_t EX3_MIN = 4'b0011;
    localparam code_t EX3_MAX = 4'b1100;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage

`default_nettype wire

// File: rtl/gray_fifo_mem.sv
// +----------------------------------------------------------------------------+
// | gray_fifo_mem: DEPTH x entry_t register array, sync write, async read      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module gray_fifo_mem
    import gray_conv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  entry_t                   wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output entry_t                   rdata_o
);

    // Storage carries no reset; occupancy logic decides what is meaningful.
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/gray_capture_fifo.sv
// +----------------------------------------------------------------------------+
// | gray_capture_fifo: captures Gray codes + error flags into a valid/ready    |
// | FIFO; counts error digits (saturating) and flags overflow (sticky).        |
// | Optional macro ERR_DROP_EN: error-flagged inputs are counted, not stored.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module gray_capture_fifo
    import gray_conv_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [CODE_W-1:0]      in_gray,
    input  logic                   in_error,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CODE_W-1:0]      out_gray,
    output logic                   out_error,
    output logic [$clog2(DEPTH):0] count,
    output logic [ERR_W-1:0]       err_cnt,
    output logic                   overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               overflow_q, overflow_d;

    occ_t   w_occ;
    logic   w_accept;
    logic   w_wr;
    logic   w_rd;
    entry_t w_wdata;
    entry_t w_head;

    always_comb begin
        w_occ = OCC_PARTIAL;
        if (count_q == '0) begin
            w_occ = OCC_EMPTY;
        end else if (count_q == c_FULL_CNT) begin
            w_occ = OCC_FULL;
        end
    end

    assign in_ready  = (w_occ != OCC_FULL);
    assign out_valid = (w_occ != OCC_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_rd      = out_valid & out_ready;

`ifdef ERR_DROP_EN
    // Error digits still complete the handshake but never reach storage.
    assign w_wr = w_accept & ~in_error;
`else
    assign w_wr = w_accept;
`endif

    assign w_wdata = '{err: in_error, code: in_gray};

    gray_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (w_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_head)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_cnt_d  = err_cnt_q;
        overflow_d = overflow_q;

        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_rd) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_wr && !w_rd) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (!w_wr && w_rd) begin
            count_d = count_q - c_CNT_W'(1);
        end
        if (w_accept && in_error && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_cnt_q  <= err_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_gray = out_valid ? w_head.code : '0;
`ifdef ERR_DROP_EN
    assign out_error = 1'b0;
`else
    assign out_error = out_valid & w_head.err;
`endif

    assign count    = count_q;
    assign err_cnt  = err_cnt_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_capture_fifo.sv
// +----------------------------------------------------------------------------+
// | tb_gray_capture_fifo: directed vector table plus multi-cycle sequences      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gray_capture_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_gray;
    logic       in_error;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_gray;
    logic       out_error;
    logic [3:0] count;
    logic [7:0] err_cnt;
    logic       overflow;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [3:0] s_out_gray;
    logic       s_out_error;
    logic [3:0] s_count;
    logic [1:0] s_err_cnt;
    logic       s_overflow;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef ERR_DROP_EN
    localparam bit c_DROP = 1'b1;
`else
    localparam bit c_DROP = 1'b0;
`endif

    gray_capture_fifo #(.DEPTH(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .in_error  (in_error),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_error (out_error),
        .count     (count),
        .err_cnt   (err_cnt),
        .overflow  (overflow)
    );

    // Narrow error counter instance sharing the same stimulus.
    gray_capture_fifo #(.DEPTH(8), .ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .in_error  (in_error),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_gray  (s_out_gray),
        .out_error (s_out_error),
        .count     (s_count),
        .err_cnt   (s_err_cnt),
        .overflow  (s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] ig;
        logic       ie;
        logic       ordy;
        logic [3:0] e_cnt;
        logic       e_ov;
        logic       e_ir;
        logic [3:0] e_og;
        logic       e_oe;
        logic [7:0] e_err;
        logic [1:0] e_sat;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] model[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [3:0] ig, input logic ie, input logic ordy);
        in_valid  = iv;
        in_gray   = ig;
        in_error  = ie;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic iv, input logic [3:0] ig, input logic ie, input logic ordy,
                        input logic [3:0] cnt, input logic ov, input logic [3:0] og,
                        input logic oe, input logic [7:0] er, input logic [1:0] sat);
        vec_t v;
        v.iv = iv; v.ig = ig; v.ie = ie; v.ordy = ordy;
        v.e_cnt = cnt; v.e_ov = ov; v.e_ir = (cnt != 4'd8);
        v.e_og = og; v.e_oe = oe; v.e_err = er; v.e_sat = sat;
        vq.push_back(v);
    endtask

    initial begin
        logic [3:0] code;
        logic [3:0] ec;

        rst_n = 1'b1; in_valid = 1'b0; in_gray = '0; in_error = 1'b0; out_ready = 1'b0;

        // Normal ordering: three writes, then three reads and one read while empty.
        addv(1, 4'b0010, 0, 0, 1, 1, 4'b0010, 0, 0, 0);
        addv(1, 4'b0110, 0, 0, 2, 1, 4'b0010, 0, 0, 0);
        addv(1, 4'b0111, 0, 0, 3, 1, 4'b0010, 0, 0, 0);
        addv(0, 4'b0000, 0, 1, 2, 1, 4'b0110, 0, 0, 0);
        addv(0, 4'b0000, 0, 1, 1, 1, 4'b0111, 0, 0, 0);
        addv(0, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
        addv(0, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
        // Error-flagged digits; last two also read so the narrow counter saturates at 3.
        for (int i = 1; i <= 3; i++) begin
            ec = c_DROP ? 4'd0 : 4'(i);
            addv(1, 4'b0000, 1, 0, ec, !c_DROP, 4'b0000, !c_DROP, 8'(i), 2'(i));
        end
        ec = c_DROP ? 4'd0 : 4'd3;
        addv(1, 4'b0000, 1, 1, ec, !c_DROP, 4'b0000, !c_DROP, 8'd4, 2'd3);
        addv(1, 4'b0000, 1, 1, ec, !c_DROP, 4'b0000, !c_DROP, 8'd5, 2'd3);
        for (int i = 2; i >= 0; i--) begin
            ec = c_DROP ? 4'd0 : 4'(i);
            addv(0, 4'b0000, 0, 1, ec, (ec != 0), 4'b0000, (ec != 0), 8'd5, 2'd3);
        end

        rst_n = 1'b0;
        step(0, 4'h0, 0, 0);
        rst_n = 1'b1;
        chk("reset count", 32'(count), 0);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset overflow", 32'(overflow), 0);
        chk("reset err_cnt", 32'(err_cnt), 0);
        chk("reset out_gray", 32'(out_gray), 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].iv, vq[i].ig, vq[i].ie, vq[i].ordy);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vq[i].e_cnt));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
            chk($sformatf("vec%0d out_gray", i), 32'(out_gray), 32'(vq[i].e_og));
            chk($sformatf("vec%0d out_error", i), 32'(out_error), 32'(vq[i].e_oe));
            chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(vq[i].e_err));
            chk($sformatf("vec%0d sat_err_cnt", i), 32'(s_err_cnt), 32'(vq[i].e_sat));
        end

        // Fill to full, then one rejected input.
        for (int i = 0; i < 8; i++) begin
            code = 4'((i * 5 + 1) % 16);
            model.push_back(code);
            step(1, code, 0, 0);
            chk($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
        end
        chk("full in_ready", 32'(in_ready), 0);
        chk("full overflow pre", 32'(overflow), 0);
        step(1, 4'hF, 0, 0);
        chk("overflow set", 32'(overflow), 1);
        chk("overflow count", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d head", i), 32'(out_gray), 32'(model[0]));
            void'(model.pop_front());
            step(0, 4'h0, 0, 1);
        end
        chk("drained out_valid", 32'(out_valid), 0);
        chk("drained out_gray", 32'(out_gray), 0);

        // Steady flow at occupancy 4 across pointer wrap.
        for (int i = 0; i < 4; i++) begin
            code = 4'(i + 3);
            model.push_back(code);
            step(1, code, 0, 0);
        end
        chk("flow start count", 32'(count), 4);
        for (int i = 0; i < 10; i++) begin
            code = 4'((i * 7 + 9) % 16);
            chk($sformatf("flow%0d head", i), 32'(out_gray), 32'(model[0]));
            void'(model.pop_front());
            model.push_back(code);
            step(1, code, 0, 1);
            chk($sformatf("flow%0d count", i), 32'(count), 4);
        end
        chk("flow final head", 32'(out_gray), 32'(model[0]));

        // Hold stability with out_ready low.
        code = out_gray;
        step(0, 4'h0, 0, 0);
        chk("hold head", 32'(out_gray), 32'(code));

        step(1, 4'hA, 0, 0);
        chk("pre-reset count", 32'(count), 5);
        chk("pre-reset overflow sticky", 32'(overflow), 1);
        chk("pre-reset err_cnt", 32'(err_cnt), 5);

        rst_n = 1'b0;
        step(1, 4'hC, 1, 1);
        rst_n = 1'b1;
        chk("midreset count", 32'(count), 0);
        chk("midreset overflow", 32'(overflow), 0);
        chk("midreset err_cnt", 32'(err_cnt), 0);
        chk("midreset sat_err_cnt", 32'(s_err_cnt), 0);
        chk("midreset in_ready", 32'(in_ready), 1);
        chk("midreset out_valid", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
